// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
//
// Sequencer for an external 8-bit ALU. It accepts one instruction at a time
// over a valid/ready handshake and drives the ALU operands and select lines.
// It samples the ALU result and carry to update an 8-bit accumulator and the
// C/Z flags. MUL is an 8-iteration shift-add loop that reuses the ALU adder.
//
// Parameters
//   MUL_EN   1: opcode 9 (MUL) is legal; 0: opcode 9 retires as illegal
//   ACC_RST  accumulator value after reset
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   instr_valid/ready instruction handshake; ready only in IDLE
//   opcode, operand   instruction fields, captured on accept
//   alu_a, alu_b      ALU operands
//   s0..s4            ALU selects: {s1,s0} output mux (00 sum, 01 a&b,
//                     10 a, 11 b), s2 carry-in, s3 invert B, s4 zero B
//   alu_z, alu_carry  ALU result and adder carry-out (combinational)
//   acc, flag_c/z     architectural accumulator and flags
//   done              one-cycle pulse when an instruction retires
//   illegal           pulse with done for an undefined opcode
// -----------------------------------------------------------------------------
module alu_ctrl_seq #(
  parameter bit         MUL_EN  = 1'b1,
  parameter logic [7:0] ACC_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] opcode,
  input  logic [7:0] operand,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       s4,
  input  logic [7:0] alu_z,
  input  logic       alu_carry,
  output logic [7:0] acc,
  output logic       flag_c,
  output logic       flag_z,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RET  = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDI = 4'd1,
    OP_ADD = 4'd2,
    OP_ADC = 4'd3,
    OP_SUB = 4'd4,
    OP_AND = 4'd5,
    OP_INC = 4'd6,
    OP_DEC = 4'd7,
    OP_CMP = 4'd8,
    OP_MUL = 4'd9
  } opcode_e;

  // Select vector ordered {s4, s3, s2, s1, s0}.
  localparam logic [4:0] SEL_IDLE = 5'b00100;
  localparam logic [4:0] SEL_LDI  = 5'b00011;
  localparam logic [4:0] SEL_ADD  = 5'b00000;
  localparam logic [4:0] SEL_SUB  = 5'b01100;
  localparam logic [4:0] SEL_AND  = 5'b00001;
  localparam logic [4:0] SEL_INC  = 5'b10100;
  localparam logic [4:0] SEL_DEC  = 5'b11000;

  state_e     state, state_d;
  opcode_e    op_r;
  logic [7:0] op_b;
  logic       illegal_r;

  // Multiply loop: partial product, shifted multiplicand, multiplier, count.
  logic [7:0] mul_p, mul_m, mul_q;
  logic [2:0] mul_i;

  logic [4:0] sel;
  logic       accept;
  logic       acc_we, c_we, z_we;
  logic [7:0] acc_d;
  logic       c_d;
  logic       opcode_illegal;

  assign accept         = instr_valid && instr_ready;
  assign opcode_illegal = (opcode >= 4'd10) || ((opcode == 4'd9) && !MUL_EN);
  assign {s4, s3, s2, s1, s0} = sel;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    alu_a       = acc;
    alu_b       = 8'h00;
    sel         = SEL_IDLE;
    acc_we      = 1'b0;
    c_we        = 1'b0;
    z_we        = 1'b0;
    acc_d       = alu_z;
    c_d         = alu_carry;

    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_d = ((opcode == 4'd9) && MUL_EN) ? MUL : EXEC;
        end
      end

      EXEC: begin
        state_d = RET;
        if (!illegal_r) begin
          unique case (op_r)
            OP_LDI: begin alu_b = op_b; sel = SEL_LDI; acc_we = 1'b1; z_we = 1'b1; end
            OP_ADD: begin alu_b = op_b; sel = SEL_ADD; acc_we = 1'b1; c_we = 1'b1; z_we = 1'b1; end
            OP_ADC: begin
              alu_b  = op_b;
              sel    = {2'b00, flag_c, 2'b00};
              acc_we = 1'b1;
              c_we   = 1'b1;
              z_we   = 1'b1;
            end
            OP_SUB: begin alu_b = op_b; sel = SEL_SUB; acc_we = 1'b1; c_we = 1'b1; z_we = 1'b1; end
            OP_AND: begin alu_b = op_b; sel = SEL_AND; acc_we = 1'b1; z_we = 1'b1; end
            OP_INC: begin sel = SEL_INC; acc_we = 1'b1; c_we = 1'b1; z_we = 1'b1; end
            OP_DEC: begin sel = SEL_DEC; acc_we = 1'b1; c_we = 1'b1; z_we = 1'b1; end
            // Compare updates flags only; the accumulator keeps its value.
            OP_CMP: begin alu_b = op_b; sel = SEL_SUB; c_we = 1'b1; z_we = 1'b1; end
            default: ;  // NOP leaves the ALU at its idle drive
          endcase
        end
      end

      MUL: begin
        // p + (q[0] ? m : 0): zeroing adder B skips the add for a 0 bit.
        alu_a = mul_p;
        alu_b = mul_m;
        sel   = {~mul_q[0], 4'b0000};
        if (mul_i == 3'd7) begin
          state_d = RET;
          acc_we  = 1'b1;
          c_we    = 1'b1;
          z_we    = 1'b1;
          c_d     = 1'b0;
        end
      end

      RET: begin
        done    = 1'b1;
        illegal = illegal_r;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_r      <= OP_NOP;
      op_b      <= 8'h00;
      illegal_r <= 1'b0;
      mul_p     <= 8'h00;
      mul_m     <= 8'h00;
      mul_q     <= 8'h00;
      mul_i     <= 3'd0;
      acc       <= ACC_RST;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      state <= state_d;

      if (accept) begin
        op_r      <= opcode_e'(opcode);
        op_b      <= operand;
        illegal_r <= opcode_illegal;
        mul_p     <= 8'h00;
        mul_m     <= acc;
        mul_q     <= operand;
        mul_i     <= 3'd0;
      end else if (state == MUL) begin
        mul_p <= alu_z;
        mul_m <= {mul_m[6:0], 1'b0};
        mul_q <= {1'b0, mul_q[7:1]};
        mul_i <= mul_i + 3'd1;
      end

      if (acc_we) acc    <= acc_d;
      if (c_we)   flag_c <= c_d;
      if (z_we)   flag_z <= (alu_z == 8'h00);
    end
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Sequencer on the driving side of the 8-bit ALU. It accepts instructions over a valid/ready handshake and drives the ALU operands and select lines s0..s4. It samples the ALU result and carry, then updates an accumulator and the C/Z flags. Multiply is a multi-cycle shift-add loop built on the ALU adder; no separate datapath is added.

Parameters:
MUL_EN, 1, when 1 opcode 9 (MUL) is legal; when 0 it is treated as illegal.
ACC_RST, 8'h00, accumulator value after reset.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept
opcode  in  4  operation, sampled on accept
operand  in  8  immediate B operand, sampled on accept
alu_a  out  8  ALU A operand
alu_b  out  8  ALU B operand
s0, s1  out  1 each  ALU output select {s1,s0}: 00=sum, 01=a&b, 10=a, 11=b
s2  out  1  adder carry-in
s3  out  1  invert B before the adder
s4  out  1  force adder B to zero
alu_z  in  8  ALU result, combinational from alu_a/alu_b/s*
alu_carry  in  1  adder carry out
acc  out  8  accumulator
flag_c  out  1  carry flag
flag_z  out  1  zero flag
done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse, coincident with done, for an undefined opcode

Behaviour:
- Reset values (asynchronous on rst=1):
  - States and registers: state=IDLE, acc=ACC_RST, flag_c=0, flag_z=0, done=0, illegal=0, instr_ready=1, all MUL registers 0.
  - ALU drive: alu_a=acc, alu_b=0, select lines {s4..s0}=00100 binary.
- Reset mid-instruction: the instruction is discarded, with no done pulse and no partial acc or flag write.
- States: IDLE, EXEC, MUL, RET.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, register opcode and operand and go to EXEC (or MUL for opcode 9 with MUL_EN=1).
- EXEC (1 cycle):
  - Drive alu_a=acc, alu_b=op_b and the select lines per opcode.
  - At the closing edge, write acc/flags from alu_z/alu_carry, then go to RET.
- RET (1 cycle): done=1, instr_ready=0, then go to IDLE. Latency from accept edge to done is 2 cycles; throughput is one instruction per 3 cycles.
- instr_ready=0 in EXEC, MUL and RET. instr_valid is ignored there; opcode and operand may change freely.
- Opcodes, as (s4 s3 s2 s1 s0) -> effect:
  - 0 NOP: no ALU drive, acc and flags unchanged.
  - 1 LDI (00011): acc=operand, Z updated, C unchanged.
  - 2 ADD (00000): acc=acc+operand, C=carry, Z updated.
  - 3 ADC: as ADD with s2=flag_c.
  - 4 SUB (01100): acc=acc+~operand+1; C=1 means no borrow.
  - 5 AND (00001): C unchanged.
  - 6 INC (10100): acc+1, C=carry.
  - 7 DEC (11000): acc+FF, C=carry (0 only when acc was 00).
  - 8 CMP: SUB selects, flags only, acc unchanged.
  - 9 MUL: see below.
  - 10..15, or 9 with MUL_EN=0: illegal. No state change; illegal=1 together with done in RET.
- Flag rule: Z is (result==0) for every opcode that writes a result, including CMP. NOP and illegal opcodes leave flags untouched.
- MUL (8 iterations, state MUL):
  - On entry: p=0, m=acc, q=operand, iteration counter i=0.
  - Each cycle: drive alu_a=p, alu_b=m, sum select, s2=0, s3=0, s4=~q[0]. Then p<=alu_z, m<=m<<1, q<=q>>1, i<=i+1.
  - After i=7: acc=p (low byte of the product), C=0, Z=(p==0), go to RET.
  - Latency from accept to done is 9 cycles.
- All arithmetic is 8-bit modulo 256. The result is sampled only from alu_z, so the ALU must be connected for correct function.

Test Plan:
1. Reset then LDI 8'h7F, ADD 8'h01 -> acc=80, C=0, Z=0; done 2 cycles after each accept edge.
2. LDI FF, ADD 01 -> acc=00, C=1, Z=1; then ADC 00 -> acc=01, C=0.
3. LDI 05, SUB 07 -> acc=FE, C=0; CMP FE -> acc=FE, Z=1, C=1; DEC with acc=00 -> acc=FF, C=0.
4. LDI 0D, MUL 0B -> acc=8F after 9 cycles. LDI 10, MUL 10 -> acc=00, Z=1, C=0.
5. opcode 4'hC -> illegal=1 and done=1 in the same cycle, acc and flags unchanged. With MUL_EN=0, opcode 9 behaves the same.
6. Assert rst during MUL iteration 4 -> acc=ACC_RST, no done pulse, instr_ready=1 immediately. Hold instr_valid high continuously -> one accept every 3 cycles.
